// File: rtl/gfx_fragment64.sv
// Fragment stage: optionally fetches a texel over the 64-bit texture bus,
// applies colorkey discard and hands the pixel to the blender.
module gfx_fragment64 #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   texture_enable_i,
  input  logic                   colorkey_enable_i,
  input  logic [31:0]            colorkey_i,
  input  logic [1:0]             color_depth_i,
  input  logic [31:3]            tex0_base_i,
  input  logic [point_width-1:0] tex0_size_x_i,
  input  logic [point_width-1:0] tex0_size_y_i,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [point_width-1:0] u_i,
  input  logic [point_width-1:0] v_i,
  input  logic [7:0]             a_i,
  input  logic [31:0]            color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  output logic [31:3]            texture_addr_o,
  output logic [7:0]             texture_sel_o,
  output logic                   texture_request_o,
  input  logic                   texture_ack_i,
  input  logic [63:0]            texture_data_i,
  output logic [point_width-1:0] pixel_x_o,
  output logic [point_width-1:0] pixel_y_o,
  output logic [point_width-1:0] pixel_z_o,
  output logic [31:0]            color_o,
  output logic [7:0]             a_o,
  output logic                   write_o,
  input  logic                   ack_i
);

  typedef enum logic [1:0] {
    ST_WAIT     = 2'd0,
    ST_TEX_READ = 2'd1,
    ST_WRITE    = 2'd2
  } state_t;

  state_t                 r_state;
  logic [point_width-1:0] r_x;
  logic [point_width-1:0] r_y;
  logic [point_width-1:0] r_z;
  logic [point_width-1:0] r_u;
  logic [point_width-1:0] r_v;
  logic [7:0]             r_a;
  logic [31:0]            r_color;
  logic                   r_write;
  logic                   r_ack;
  logic                   r_texReq;

  logic [31:0] w_offsetRaw;
  logic [31:0] w_offset;
  logic [2:0]  w_lsb;
  logic [31:3] w_texAddr;
  logic [31:0] w_texel;
  logic [31:0] w_keyMasked;
  logic        w_keyHit;
  logic        w_outOfRange;

  // Texel index scaled to a byte offset by the texel size of the active depth.
  always_comb begin
    w_offsetRaw = 32'(r_v) * 32'(tex0_size_x_i) + 32'(r_u);
    case (color_depth_i)
      2'b00:   w_offset = w_offsetRaw;
      2'b01:   w_offset = w_offsetRaw << 1;
      default: w_offset = w_offsetRaw << 2;
    endcase
    w_lsb     = w_offset[2:0];
    w_texAddr = tex0_base_i + w_offset[31:3];
  end

  // Lane select within the 64-bit word; colorkey compared at the same width.
  always_comb begin
    w_texel     = '0;
    w_keyMasked = '0;
    case (color_depth_i)
      2'b00: begin
        w_texel     = {24'd0, texture_data_i[{w_lsb, 3'b000} +: 8]};
        w_keyMasked = {24'd0, colorkey_i[7:0]};
      end
      2'b01: begin
        w_texel     = {16'd0, texture_data_i[{w_lsb[2:1], 4'b0000} +: 16]};
        w_keyMasked = {16'd0, colorkey_i[15:0]};
      end
      default: begin
        w_texel     = texture_data_i[{w_lsb[2], 5'b00000} +: 32];
        w_keyMasked = colorkey_i;
      end
    endcase
    w_keyHit     = colorkey_enable_i && (w_texel == w_keyMasked);
    w_outOfRange = (u_i >= tex0_size_x_i) || (v_i >= tex0_size_y_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_WAIT;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_u      <= '0;
      r_v      <= '0;
      r_a      <= '0;
      r_color  <= '0;
      r_write  <= 1'b0;
      r_ack    <= 1'b0;
      r_texReq <= 1'b0;
    end else begin
      r_write <= 1'b0;
      r_ack   <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (write_i) begin
            r_x <= pixel_x_i;
            r_y <= pixel_y_i;
            r_z <= pixel_z_i;
            r_u <= u_i;
            r_v <= v_i;
            r_a <= a_i;
            if (!texture_enable_i) begin
              r_color <= color_i;
              r_write <= 1'b1;
              r_state <= ST_WRITE;
            end else if (w_outOfRange) begin
              r_color <= '0;
              r_write <= 1'b1;
              r_state <= ST_WRITE;
            end else begin
              r_texReq <= 1'b1;
              r_state  <= ST_TEX_READ;
            end
          end
        end
        ST_TEX_READ: begin
          if (texture_ack_i) begin
            r_texReq <= 1'b0;
            if (w_keyHit) begin
              r_ack   <= 1'b1;
              r_state <= ST_WAIT;
            end else begin
              r_color <= w_texel;
              r_write <= 1'b1;
              r_state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (ack_i) begin
            r_ack   <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  // Address is only driven while a read is outstanding so reset leaves it at zero.
  assign texture_addr_o    = r_texReq ? w_texAddr : '0;
  assign texture_sel_o     = 8'hFF;
  assign texture_request_o = r_texReq;
  assign ack_o             = r_ack;
  assign write_o           = r_write;
  assign color_o           = r_color;
  assign a_o               = r_a;
  assign pixel_x_o         = r_x;
  assign pixel_y_o         = r_y;
  assign pixel_z_o         = r_z;

endmodule

// File: tb/tb_gfx_fragment64.sv
// Directed and randomized pixels checked against a byte-address model of
// texel fetch, colorkey discard and the accept/write/ack handshake.
module tb_gfx_fragment64;

  localparam int PW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          texture_enable_i;
  logic          colorkey_enable_i;
  logic [31:0]   colorkey_i;
  logic [1:0]    color_depth_i;
  logic [31:3]   tex0_base_i;
  logic [PW-1:0] tex0_size_x_i;
  logic [PW-1:0] tex0_size_y_i;
  logic [PW-1:0] pixel_x_i;
  logic [PW-1:0] pixel_y_i;
  logic [PW-1:0] pixel_z_i;
  logic [PW-1:0] u_i;
  logic [PW-1:0] v_i;
  logic [7:0]    a_i;
  logic [31:0]   color_i;
  logic          write_i;
  logic          ack_o;
  logic [31:3]   texture_addr_o;
  logic [7:0]    texture_sel_o;
  logic          texture_request_o;
  logic          texture_ack_i;
  logic [63:0]   texture_data_i;
  logic [PW-1:0] pixel_x_o;
  logic [PW-1:0] pixel_y_o;
  logic [PW-1:0] pixel_z_o;
  logic [31:0]   color_o;
  logic [7:0]    a_o;
  logic          write_o;
  logic          ack_i;

  int checks   = 0;
  int failures = 0;

  // Stimulus for the pixel currently being run
  logic          sTex;
  logic          sCkEn;
  logic [31:0]   sCk;
  logic [1:0]    sDepth;
  logic [28:0]   sBase;
  logic [PW-1:0] sSx, sSy, sX, sY, sZ, sU, sV;
  logic [7:0]    sA;
  logic [31:0]   sColor;
  logic [63:0]   sData;
  int            sTexDelay;
  int            sAckDelay;

  gfx_fragment64 #(.point_width(PW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .texture_enable_i(texture_enable_i), .colorkey_enable_i(colorkey_enable_i),
    .colorkey_i(colorkey_i), .color_depth_i(color_depth_i),
    .tex0_base_i(tex0_base_i), .tex0_size_x_i(tex0_size_x_i), .tex0_size_y_i(tex0_size_y_i),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
    .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i), .write_i(write_i),
    .ack_o(ack_o), .texture_addr_o(texture_addr_o), .texture_sel_o(texture_sel_o),
    .texture_request_o(texture_request_o), .texture_ack_i(texture_ack_i),
    .texture_data_i(texture_data_i), .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o),
    .pixel_z_o(pixel_z_o), .color_o(color_o), .a_o(a_o), .write_o(write_o), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic int bytesPer(input logic [1:0] d);
    return (d == 2'b00) ? 1 : (d == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] maskOf(input logic [1:0] d);
    return (d == 2'b00) ? 32'h0000_00FF : (d == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic longint byteOffset(input logic [PW-1:0] sx, input logic [PW-1:0] u,
                                        input logic [PW-1:0] v, input logic [1:0] d);
    return (longint'(v) * longint'(sx) + longint'(u)) * longint'(bytesPer(d));
  endfunction

  function automatic logic [28:0] modelAddr(input logic [28:0] base, input logic [PW-1:0] sx,
                                            input logic [PW-1:0] u, input logic [PW-1:0] v,
                                            input logic [1:0] d);
    longint word;
    word = longint'(base) + (byteOffset(sx, u, v, d) >> 3);
    return 29'(word);
  endfunction

  function automatic logic [31:0] modelTexel(input logic [63:0] data, input logic [PW-1:0] sx,
                                             input logic [PW-1:0] u, input logic [PW-1:0] v,
                                             input logic [1:0] d);
    int lane;
    lane = int'(byteOffset(sx, u, v, d) % 8);
    return 32'((data >> (8 * lane)) & {32'd0, maskOf(d)});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_write", 64'(write_o), 64'd0);
    checkOutput("rst_ack", 64'(ack_o), 64'd0);
    checkOutput("rst_req", 64'(texture_request_o), 64'd0);
    checkOutput("rst_addr", 64'(texture_addr_o), 64'd0);
    checkOutput("rst_sel", 64'(texture_sel_o), 64'hFF);
    checkOutput("rst_color", 64'(color_o), 64'd0);
    checkOutput("rst_x", 64'(pixel_x_o), 64'd0);
    checkOutput("rst_y", 64'(pixel_y_o), 64'd0);
    checkOutput("rst_z", 64'(pixel_z_o), 64'd0);
    checkOutput("rst_a", 64'(a_o), 64'd0);
  endtask

  task automatic applyStimulus();
    texture_enable_i  = sTex;
    colorkey_enable_i = sCkEn;
    colorkey_i        = sCk;
    color_depth_i     = sDepth;
    tex0_base_i       = sBase;
    tex0_size_x_i     = sSx;
    tex0_size_y_i     = sSy;
    pixel_x_i         = sX;
    pixel_y_i         = sY;
    pixel_z_i         = sZ;
    u_i               = sU;
    v_i               = sV;
    a_i               = sA;
    color_i           = sColor;
    write_i           = 1'b1;
  endtask

  // Runs one pixel from a negedge; returns at the negedge where ack_o is high.
  task automatic runPixel();
    logic [28:0] eAddr;
    logic [31:0] eTexel;
    logic [31:0] eColor;
    bit          oor;
    bit          discard;
    eAddr   = modelAddr(sBase, sSx, sU, sV, sDepth);
    eTexel  = modelTexel(sData, sSx, sU, sV, sDepth);
    oor     = (sU >= sSx) || (sV >= sSy);
    discard = sTex && !oor && sCkEn && ((sCk & maskOf(sDepth)) == eTexel);
    applyStimulus();
    @(negedge clk_i);
    write_i = 1'b0;
    checkOutput("ack_idle", 64'(ack_o), 64'd0);
    checkOutput("pix_x", 64'(pixel_x_o), 64'(sX));
    checkOutput("pix_y", 64'(pixel_y_o), 64'(sY));
    checkOutput("pix_z", 64'(pixel_z_o), 64'(sZ));
    checkOutput("alpha", 64'(a_o), 64'(sA));
    if (!sTex || oor) begin
      eColor = sTex ? 32'd0 : sColor;
      checkOutput("write_flat", 64'(write_o), 64'd1);
      checkOutput("color_flat", 64'(color_o), 64'(eColor));
      checkOutput("no_req", 64'(texture_request_o), 64'd0);
    end else begin
      checkOutput("req_rise", 64'(texture_request_o), 64'd1);
      checkOutput("tex_addr", 64'(texture_addr_o), 64'(eAddr));
      checkOutput("sel", 64'(texture_sel_o), 64'hFF);
      checkOutput("write_early", 64'(write_o), 64'd0);
      for (int i = 0; i < sTexDelay; i++) begin
        ack_i   = 1'b1;
        write_i = 1'b1;
        @(negedge clk_i);
        checkOutput("req_hold", 64'(texture_request_o), 64'd1);
        checkOutput("ack_in_read", 64'(ack_o), 64'd0);
        checkOutput("write_in_read", 64'(write_o), 64'd0);
      end
      ack_i          = 1'b0;
      write_i        = 1'b0;
      texture_ack_i  = 1'b1;
      texture_data_i = sData;
      @(negedge clk_i);
      texture_ack_i  = 1'b0;
      texture_data_i = {$urandom, $urandom};
      checkOutput("req_drop", 64'(texture_request_o), 64'd0);
      if (discard) begin
        checkOutput("discard_ack", 64'(ack_o), 64'd1);
        checkOutput("discard_nowrite", 64'(write_o), 64'd0);
        return;
      end
      eColor = eTexel;
      checkOutput("write_tex", 64'(write_o), 64'd1);
      checkOutput("color_tex", 64'(color_o), 64'(eColor));
      checkOutput("ack_tex", 64'(ack_o), 64'd0);
    end
    for (int i = 0; i < sAckDelay; i++) begin
      texture_ack_i = 1'b1;
      write_i       = 1'b1;
      @(negedge clk_i);
      checkOutput("write_single", 64'(write_o), 64'd0);
      checkOutput("ack_in_write", 64'(ack_o), 64'd0);
      checkOutput("color_hold", 64'(color_o), 64'(eColor));
    end
    texture_ack_i = 1'b0;
    write_i       = 1'b0;
    ack_i         = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    checkOutput("done_ack", 64'(ack_o), 64'd1);
    checkOutput("done_nowrite", 64'(write_o), 64'd0);
  endtask

  // Spurious acks while idle must not produce output pulses.
  task automatic idleCycle();
    ack_i         = 1'b1;
    texture_ack_i = 1'b1;
    @(negedge clk_i);
    ack_i         = 1'b0;
    texture_ack_i = 1'b0;
    checkOutput("idle_ack", 64'(ack_o), 64'd0);
    checkOutput("idle_write", 64'(write_o), 64'd0);
    checkOutput("idle_req", 64'(texture_request_o), 64'd0);
  endtask

  task automatic setDefaults();
    sTex = 1'b0; sCkEn = 1'b0; sCk = 32'd0; sDepth = 2'b11; sBase = 29'd0;
    sSx = 16'd16; sSy = 16'd16; sX = 16'd1; sY = 16'd2; sZ = 16'd3;
    sU = 16'd0; sV = 16'd0; sA = 8'h80; sColor = 32'd0; sData = 64'd0;
    sTexDelay = 0; sAckDelay = 0;
  endtask

  initial begin
    rst_i = 1'b1;
    texture_enable_i = 1'b0; colorkey_enable_i = 1'b0; colorkey_i = '0;
    color_depth_i = '0; tex0_base_i = '0; tex0_size_x_i = '0; tex0_size_y_i = '0;
    pixel_x_i = '0; pixel_y_i = '0; pixel_z_i = '0; u_i = '0; v_i = '0;
    a_i = '0; color_i = '0; write_i = 1'b0; texture_ack_i = 1'b0;
    texture_data_i = '0; ack_i = 1'b0;
    #2;
    checkResetState();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    idleCycle();

    // Flat colour, blender acks two cycles after write_o
    setDefaults();
    sColor = 32'h1122_3344; sX = 16'd5; sY = 16'd7; sAckDelay = 2;
    runPixel();
    checkOutput("tp1_color", 64'(color_o), 64'h1122_3344);
    idleCycle();

    // 16bpp fetch from the upper halfword of the word
    setDefaults();
    sTex = 1'b1; sDepth = 2'b01; sBase = 29'h100; sSx = 16'd10; sSy = 16'd10;
    sU = 16'd3; sV = 16'd2; sData = 64'hDDDD_CCCC_BBBB_AAAA; sAckDelay = 1;
    runPixel();
    checkOutput("tp2_color", 64'(color_o), 64'h0000_DDDD);

    // 8bpp colorkey hit is discarded, issued back-to-back with the previous ack
    setDefaults();
    sTex = 1'b1; sDepth = 2'b00; sBase = 29'h40; sCkEn = 1'b1; sCk = 32'h0000_00FF;
    sU = 16'd2; sV = 16'd0; sData = 64'h1234_5678_9AFF_0102;
    runPixel();
    idleCycle();

    // u equal to the texture width: no fetch, black pixel
    setDefaults();
    sTex = 1'b1; sSx = 16'd8; sU = 16'd8; sColor = 32'hCAFE_F00D;
    runPixel();
    checkOutput("tp4_color", 64'(color_o), 64'd0);

    // Slow texture memory
    setDefaults();
    sTex = 1'b1; sDepth = 2'b11; sBase = 29'h1F_0000; sU = 16'd5; sV = 16'd3;
    sData = 64'h0BAD_F00D_DEAD_BEEF; sTexDelay = 20;
    runPixel();
    idleCycle();

    // Reset while a read is outstanding, then a fresh pixel
    setDefaults();
    sTex = 1'b1; sU = 16'd1; sV = 16'd1; sColor = 32'h5555_5555;
    applyStimulus();
    @(negedge clk_i);
    write_i = 1'b0;
    checkOutput("pre_rst_req", 64'(texture_request_o), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkResetState();
    @(negedge clk_i);
    rst_i = 1'b0;
    setDefaults();
    sTex = 1'b1; sDepth = 2'b10; sBase = 29'h77; sU = 16'd3; sV = 16'd1;
    sData = 64'h8765_4321_0FED_CBA9; sTexDelay = 2; sAckDelay = 1;
    runPixel();
    idleCycle();

    // Randomized pixels, sometimes back-to-back
    for (int n = 0; n < 40; n++) begin
      logic [31:0] texel;
      setDefaults();
      sTex      = ($urandom_range(0, 3) != 0);
      sDepth    = 2'($urandom_range(0, 3));
      sSx       = 16'($urandom_range(1, 64));
      sSy       = 16'($urandom_range(1, 64));
      sU        = 16'($urandom_range(0, int'(sSx)));
      sV        = 16'($urandom_range(0, int'(sSy)));
      sBase     = 29'($urandom);
      sData     = {$urandom, $urandom};
      sColor    = $urandom;
      sX        = 16'($urandom);
      sY        = 16'($urandom);
      sZ        = 16'($urandom);
      sA        = 8'($urandom);
      sCkEn     = 1'($urandom_range(0, 1));
      sCk       = $urandom;
      texel     = modelTexel(sData, sSx, sU, sV, sDepth);
      if ($urandom_range(0, 2) == 0)
        sCk = (sCk & ~maskOf(sDepth)) | texel;
      sTexDelay = $urandom_range(0, 4);
      sAckDelay = $urandom_range(0, 3);
      runPixel();
      if ($urandom_range(0, 1) == 1)
        idleCycle();
    end
    idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
